// File: rtl/wdt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_ctrl_pkg
//  Purpose  : Shared types and constants for the watchdog reset controller:
//             the controller state enum, the fault counter width and the
//             width helper for the reset-stretch down-counter.
//  Ports    : none (package)
//  Macros   : none
//  Revision : 1.0  initial release
// ============================================================================
package wdt_ctrl_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HOLD    = 2'd1,
    RECOVER = 2'd2,
    LOCKOUT = 2'd3
  } wdt_state_t;

  localparam int FAULT_W = 4;

  // Counter width able to hold RST_CYCLES-1; never narrower than one bit.
  function automatic int stretch_w(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdt_pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_pulse_stretch
//  Purpose  : Loadable down-counter that times the system reset pulse.
//             A load starts a run from cnt; the run ends one cycle after the
//             count reaches zero, so a load of L keeps busy high L+1 cycles.
//  Ports    : clk   - clock, rising edge
//             rst   - synchronous active-high reset
//             load  - start a new run from cnt
//             cnt   - start value of the run
//             busy  - a run is in progress
//             done  - last cycle of the current run (count is zero)
//  Macros   : none
//  Revision : 1.0  initial release
// ============================================================================
module wdt_pulse_stretch #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] r_count;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_count <= cnt;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wdt_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_reset_ctrl
//  Purpose  : Consumer of a 4-bit watchdog's timeout. Gates and services the
//             watchdog, stretches a timeout into a RST_CYCLES-long system
//             reset, counts faults (saturating at 15) and, when built with
//             WDT_LOCKOUT_EN defined, escalates to a sticky lockout once the
//             fault count reaches MAX_FAULTS. Without WDT_LOCKOUT_EN every
//             qualifying timeout just produces a reset pulse and lockout
//             stays 0. All outputs are flop outputs.
//  Ports    : clk         - clock, rising edge
//             rst         - synchronous active-high reset
//             timeout     - watchdog count has reached 15
//             sw_enable   - software request to arm the watchdog
//             kick        - software service pulse
//             clr_faults  - clear the fault counter
//             wdt_enable  - watchdog enable
//             wdt_restart - watchdog restart
//             sys_rst     - stretched system reset
//             lockout     - sticky escalation flag
//             fault_cnt   - saturating timeout count since last clear
//  Macros   : WDT_LOCKOUT_EN - enables escalation to LOCKOUT
//  Revision : 1.0  initial release
// ============================================================================
module wdt_reset_ctrl
  import wdt_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 8,
  parameter int MAX_FAULTS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timeout,
  input  logic               sw_enable,
  input  logic               kick,
  input  logic               clr_faults,
  output logic               wdt_enable,
  output logic               wdt_restart,
  output logic               sys_rst,
  output logic               lockout,
  output logic [FAULT_W-1:0] fault_cnt
);

  localparam int               CNT_W    = stretch_w(RST_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RST_CYCLES - 1);
  localparam logic [FAULT_W-1:0] MAX_CNT = FAULT_W'(MAX_FAULTS);
  localparam logic [FAULT_W-1:0] SAT_CNT = {FAULT_W{1'b1}};

`ifdef WDT_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  wdt_state_t         r_state;
  logic               r_wdt_enable;
  logic               r_wdt_restart;
  logic               r_sys_rst;
  logic               r_lockout;
  logic [FAULT_W-1:0] r_fault_cnt;

  logic               w_qual;
  logic               w_escalate;
  logic               w_load;
  logic               w_busy;
  logic               w_done;
  logic [FAULT_W-1:0] w_base;
  logic [FAULT_W-1:0] w_next_cnt;

  // Only a timeout seen while we are actually enabling the watchdog counts.
  assign w_qual = (r_state == ARMED) && timeout && r_wdt_enable;

  // A clear in the same cycle as a timeout is applied first, so the
  // increment lands on zero.
  assign w_base     = clr_faults ? '0 : r_fault_cnt;
  assign w_next_cnt = (w_base == SAT_CNT) ? w_base : w_base + FAULT_W'(1);

  // With escalation compiled out this is constant 0 and LOCKOUT is dead.
  assign w_escalate = LOCK_EN && (w_next_cnt >= MAX_CNT);
  assign w_load     = w_qual && !w_escalate;

  wdt_pulse_stretch #(
    .CNT_W (CNT_W)
  ) u_stretch (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .cnt  (LOAD_VAL),
    .busy (w_busy),
    .done (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARMED;
      r_wdt_enable  <= 1'b0;
      r_wdt_restart <= 1'b1;
      r_sys_rst     <= 1'b0;
      r_lockout     <= 1'b0;
      r_fault_cnt   <= '0;
    end else begin
      case (r_state)
        ARMED: begin
          if (w_qual) begin
            r_fault_cnt   <= w_next_cnt;
            r_wdt_enable  <= 1'b0;
            r_wdt_restart <= 1'b1;
            r_sys_rst     <= 1'b1;
            if (w_escalate) begin
              r_state   <= LOCKOUT;
              r_lockout <= 1'b1;
            end else begin
              r_state <= HOLD;
            end
          end else begin
            r_fault_cnt   <= w_base;
            r_wdt_enable  <= sw_enable;
            r_wdt_restart <= kick;
            r_sys_rst     <= 1'b0;
          end
        end

        HOLD: begin
          r_fault_cnt   <= w_base;
          r_wdt_enable  <= 1'b0;
          r_wdt_restart <= 1'b1;
          // An idle stretcher here cannot happen in normal flow; leaving
          // HOLD anyway keeps the block from wedging with sys_rst high.
          if (w_done || !w_busy) begin
            r_state   <= RECOVER;
            r_sys_rst <= 1'b0;
          end
        end

        RECOVER: begin
          r_fault_cnt   <= w_base;
          r_wdt_enable  <= 1'b0;
          r_wdt_restart <= 1'b1;
          r_sys_rst     <= 1'b0;
          r_state       <= ARMED;
        end

        LOCKOUT: begin
          r_wdt_enable  <= 1'b0;
          r_wdt_restart <= 1'b1;
          r_sys_rst     <= 1'b1;
          r_lockout     <= 1'b1;
        end

        default: begin
          r_state <= ARMED;
        end
      endcase
    end
  end

  assign wdt_enable  = r_wdt_enable;
  assign wdt_restart = r_wdt_restart;
  assign sys_rst     = r_sys_rst;
  assign lockout     = r_lockout;
  assign fault_cnt   = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wdt_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wdt_reset_ctrl
//  Purpose  : Self-checking bench for wdt_reset_ctrl. A 4-bit watchdog model
//             closes the loop; a timeline reference model predicts every
//             output each cycle, alongside directed literal checks.
//  Macros   : WDT_LOCKOUT_EN - selects escalation checks
//  Revision : 1.0  initial release
// ============================================================================
module tb_wdt_reset_ctrl;

  localparam int RST_CYCLES = 8;
  localparam int MAX_FAULTS = 3;
`ifdef WDT_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_enable;
  logic       kick;
  logic       clr_faults;
  logic       force_to;
  logic       timeout;
  logic       wdt_enable;
  logic       wdt_restart;
  logic       sys_rst;
  logic       lockout;
  logic [3:0] fault_cnt;
  logic [3:0] wd_cnt = 4'd0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wdt_reset_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_FAULTS (MAX_FAULTS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .timeout     (timeout),
    .sw_enable   (sw_enable),
    .kick        (kick),
    .clr_faults  (clr_faults),
    .wdt_enable  (wdt_enable),
    .wdt_restart (wdt_restart),
    .sys_rst     (sys_rst),
    .lockout     (lockout),
    .fault_cnt   (fault_cnt)
  );

  // Watchdog: counts while enabled, holds at 15, cleared by restart or disable.
  always @(posedge clk) begin
    if (!wdt_enable || wdt_restart) wd_cnt <= 4'd0;
    else if (wd_cnt != 4'd15)       wd_cnt <= wd_cnt + 4'd1;
  end
  assign timeout = (wd_cnt == 4'd15) || force_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: timeline of the current reset episode in edge numbers.
  int   k = 0;
  int   pulse_end = 0;
  int   armed_from = 0;
  bit   m_valid = 1'b0;
  bit   m_locked = 1'b0;
  logic m_en, m_restart, m_sys, m_lock;
  int   m_faults;

  initial begin
    forever begin
      int f;
      @(posedge clk);
      k++;
      if (rst) begin
        m_en = 1'b0; m_restart = 1'b1; m_sys = 1'b0; m_lock = 1'b0;
        m_faults = 0; m_locked = 1'b0; armed_from = 0; pulse_end = 0;
        m_valid = 1'b1;
      end else if (m_valid && !m_locked) begin
        f = clr_faults ? 0 : m_faults;
        if (k >= armed_from) begin
          if (timeout && m_en) begin
            f = (f >= 15) ? 15 : f + 1;
            m_sys = 1'b1; m_en = 1'b0; m_restart = 1'b1;
            if (LOCK_EN && f >= MAX_FAULTS) begin
              m_locked = 1'b1; m_lock = 1'b1;
            end else begin
              pulse_end  = k + RST_CYCLES;
              armed_from = k + RST_CYCLES + 2;
            end
          end else begin
            m_en = sw_enable; m_restart = kick; m_sys = 1'b0;
          end
        end else begin
          m_sys = (k < pulse_end); m_en = 1'b0; m_restart = 1'b1;
        end
        m_faults = f;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("m_wdt_enable",  wdt_enable,  m_en);
        chk("m_wdt_restart", wdt_restart, m_restart);
        chk("m_sys_rst",     sys_rst,     m_sys);
        chk("m_lockout",     lockout,     m_lock);
        chk("m_fault_cnt",   fault_cnt,   m_faults);
      end
    end
  end

  task automatic wait_en(input string tag);
    int n = 0;
    while (wdt_enable !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(tag, wdt_enable, 1);
  endtask

  task automatic force_one();
    wait_en("force_wait_en");
    force_to = 1'b1;
    @(negedge clk);
    force_to = 1'b0;
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    while (sys_rst === 1'b1 && n < 40) begin n++; @(negedge clk); end
  endtask

  initial begin
    int n;
    rst = 1'b1; sw_enable = 1'b0; kick = 1'b0; clr_faults = 1'b0; force_to = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_restart", wdt_restart, 1);
    chk("rst_enable",  wdt_enable,  0);
    chk("rst_sys_rst", sys_rst,     0);
    chk("rst_lockout", lockout,     0);
    chk("rst_faults",  fault_cnt,   0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_fall", wdt_restart, 0);

    // Natural timeout path.
    sw_enable = 1'b1;
    wait_en("first_enable");
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("timeout_latency", n, 15);
    @(negedge clk);
    pulse_len(n);
    chk("pulse_len_first", n, RST_CYCLES);
    chk("fault_after_first", fault_cnt, 1);
    wait_en("rearm");

    // Kicked: no timeouts.
    clr_faults = 1'b1; @(negedge clk); clr_faults = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      kick = (i % 10 == 0);
      @(negedge clk);
      if (timeout || sys_rst) n++;
    end
    kick = 1'b0;
    chk("kick_no_timeout", n, 0);
    chk("kick_faults", fault_cnt, 0);

    // Two faults, then clear coinciding with a timeout.
    force_one(); pulse_len(n); chk("pulse_len_a", n, RST_CYCLES);
    force_one(); pulse_len(n); chk("pulse_len_b", n, RST_CYCLES);
    chk("faults_two", fault_cnt, 2);
    wait_en("simul_wait");
    clr_faults = 1'b1; force_to = 1'b1;
    @(negedge clk);
    clr_faults = 1'b0; force_to = 1'b0;
    chk("simul_faults",  fault_cnt, 1);
    chk("simul_sys_rst", sys_rst,   1);
    chk("simul_lockout", lockout,   0);
    pulse_len(n); chk("simul_pulse", n, RST_CYCLES);

`ifdef WDT_LOCKOUT_EN
    clr_faults = 1'b1; @(negedge clk); clr_faults = 1'b0;
    force_one(); pulse_len(n);
    force_one(); pulse_len(n);
    force_one();
    chk("lock_flag",   lockout,   1);
    chk("lock_sys",    sys_rst,   1);
    chk("lock_faults", fault_cnt, 3);
    clr_faults = 1'b1; repeat (3) @(negedge clk); clr_faults = 1'b0;
    repeat (10) @(negedge clk);
    chk("lock_sticky",     lockout,   1);
    chk("lock_sys_sticky", sys_rst,   1);
    chk("lock_clr_ignored", fault_cnt, 3);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("unlock_flag",   lockout,   0);
    chk("unlock_sys",    sys_rst,   0);
    chk("unlock_faults", fault_cnt, 0);
`else
    for (int i = 0; i < 20; i++) begin
      force_one(); pulse_len(n);
      chk("nolock_pulse", n, RST_CYCLES);
    end
    chk("nolock_sat",  fault_cnt, 15);
    chk("nolock_flag", lockout,   0);
`endif

    // Randomized phase against the model.
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) sw_enable = ~sw_enable;
      kick       = ($urandom_range(0, 11) == 0);
      clr_faults = ($urandom_range(0, 39) == 0);
      force_to   = ($urandom_range(0, 24) == 0);
      @(negedge clk);
    end
    rst = 1'b0; kick = 1'b0; clr_faults = 1'b0; force_to = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
